dog_extrema_scanner: RTL and testbench

- Parametrised successor to the single-octave keypoint finder.
- Scans the interior of one octave's three difference-of-Gaussian layers (lower, middle, upper) held in BRAM.
- Tests each interior middle-layer pixel against its 26 neighbours in the 3x3x3 block, applies a contrast threshold and mode mask, and emits packed keypoint coordinates through a valid/ready handshake.
- One instance per octave; width, height, bit depth and BRAM read latency are parameters.

---
 rtl/dog_extrema_scanner.sv | 218 +++++++++++++++++++++
 tb/tb_dog_extrema_scanner.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dog_extrema_scanner.sv
// Difference-of-Gaussian 3x3x3 extrema scanner for one octave: walks the interior of the
// middle layer, fetches each 3x3 window from three BRAMs and emits qualifying keypoints.
`timescale 1ns/1ps
module dog_extrema_scanner #(
   parameter int          BIT_DEPTH     = 9,
   parameter int          WIDTH         = 64,
   parameter int          HEIGHT        = 64,
   parameter int          READ_LATENCY  = 2,
   parameter int unsigned THRESH        = 3,
   parameter int          MAX_KEYPOINTS = 1024,
   localparam int AW = $clog2(WIDTH*HEIGHT),
   localparam int XW = $clog2(WIDTH),
   localparam int YW = $clog2(HEIGHT),
   localparam int KW = XW + YW + 1,
   localparam int CW = $clog2(MAX_KEYPOINTS+1)
)(
   input  logic                        clk,
   input  logic                        rst_in,
   input  logic                        start,
   input  logic [1:0]                  mode,
   output logic [AW-1:0]               read_addr,
   input  logic signed [BIT_DEPTH-1:0] lo_data,
   input  logic signed [BIT_DEPTH-1:0] mid_data,
   input  logic signed [BIT_DEPTH-1:0] hi_data,
   output logic                        kp_valid,
   input  logic                        kp_ready,
   output logic [KW-1:0]               kp_data,
   output logic [CW-1:0]               kp_count,
   output logic                        overflow,
   output logic                        busy,
   output logic                        done
);

   typedef enum logic [2:0] {IDLE, FETCH, WAIT, COMPARE, EMIT, DONE} stateT;

   localparam bit DEGENERATE = (WIDTH < 3) || (HEIGHT < 3);

   stateT                        r_state;
   logic [1:0]                   r_mode;
   logic [XW-1:0]                r_x;
   logic [YW-1:0]                r_y;
   logic [3:0]                   r_k;
   logic [3:0]                   r_waitCnt;
   logic                         r_pipeValid [READ_LATENCY];
   logic [3:0]                   r_pipeIdx   [READ_LATENCY];
   logic signed [BIT_DEPTH-1:0]  r_loS  [9];
   logic signed [BIT_DEPTH-1:0]  r_midS [9];
   logic signed [BIT_DEPTH-1:0]  r_hiS  [9];

   logic signed [BIT_DEPTH-1:0]  w_c;
   logic signed [BIT_DEPTH:0]    w_cExt;
   logic signed [BIT_DEPTH:0]    w_cAbs;
   logic                         w_contrastOk;
   logic                         w_gtAll;
   logic                         w_ltAll;
   logic                         w_keypoint;
   logic                         w_room;
   logic                         w_wrapX;
   logic                         w_scanEnd;
   logic [XW-1:0]                w_nextX;
   logic [YW-1:0]                w_nextY;
   logic                         w_advance;

   // Window tap k (0..8, row-major) around centre (x,y) mapped to a linear BRAM address.
   function automatic logic [AW-1:0] addrOf(input logic [XW-1:0] x, input logic [YW-1:0] y,
                                            input logic [3:0] k);
      int row;
      int col;
      row = int'(y) + int'(k) / 3 - 1;
      col = int'(x) + int'(k) % 3 - 1;
      return AW'(row * WIDTH + col);
   endfunction

   assign w_c          = r_midS[4];
   assign w_cExt       = {w_c[BIT_DEPTH-1], w_c};
   assign w_cAbs       = w_cExt[BIT_DEPTH] ? -w_cExt : w_cExt;
   assign w_contrastOk = $unsigned(w_cAbs) >= (BIT_DEPTH+1)'(THRESH);

   // Strict comparison against all 26 neighbours; any tie disqualifies both extremum kinds.
   always_comb begin
      w_gtAll = 1'b1;
      w_ltAll = 1'b1;
      for (int i = 0; i < 9; i++) begin
         if (r_loS[i] >= w_c) w_gtAll = 1'b0;
         if (r_loS[i] <= w_c) w_ltAll = 1'b0;
         if (r_hiS[i] >= w_c) w_gtAll = 1'b0;
         if (r_hiS[i] <= w_c) w_ltAll = 1'b0;
         if (i != 4) begin
            if (r_midS[i] >= w_c) w_gtAll = 1'b0;
            if (r_midS[i] <= w_c) w_ltAll = 1'b0;
         end
      end
   end

   assign w_keypoint = ((w_gtAll & r_mode[0]) | (w_ltAll & r_mode[1])) & w_contrastOk;
   assign w_room     = kp_count < CW'(MAX_KEYPOINTS);
   assign w_wrapX    = (r_x == XW'(WIDTH-2));
   assign w_nextX    = w_wrapX ? XW'(1) : r_x + XW'(1);
   assign w_nextY    = w_wrapX ? r_y + YW'(1) : r_y;
   assign w_scanEnd  = w_wrapX && (r_y == YW'(HEIGHT-2));
   assign w_advance  = ((r_state == COMPARE) && !(w_keypoint && w_room)) ||
                       ((r_state == EMIT) && kp_ready);

   // Read-issue tracking: each issued tap travels READ_LATENCY stages, then its data lands in slot k.
   always_ff @(posedge clk or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i < READ_LATENCY; i++) begin
            r_pipeValid[i] <= 1'b0;
            r_pipeIdx[i]   <= 4'd0;
         end
         for (int i = 0; i < 9; i++) begin
            r_loS[i]  <= '0;
            r_midS[i] <= '0;
            r_hiS[i]  <= '0;
         end
      end else begin
         r_pipeValid[0] <= (r_state == FETCH);
         r_pipeIdx[0]   <= r_k;
         for (int i = 1; i < READ_LATENCY; i++) begin
            r_pipeValid[i] <= r_pipeValid[i-1];
            r_pipeIdx[i]   <= r_pipeIdx[i-1];
         end
         if (r_pipeValid[READ_LATENCY-1]) begin
            r_loS[r_pipeIdx[READ_LATENCY-1]]  <= lo_data;
            r_midS[r_pipeIdx[READ_LATENCY-1]] <= mid_data;
            r_hiS[r_pipeIdx[READ_LATENCY-1]]  <= hi_data;
         end
      end
   end

   // Scan controller; the centre-advance at the bottom overrides the state chosen in the case.
   always_ff @(posedge clk or posedge rst_in) begin
      if (rst_in) begin
         r_state   <= IDLE;
         r_mode    <= 2'b00;
         r_x       <= '0;
         r_y       <= '0;
         r_k       <= 4'd0;
         r_waitCnt <= 4'd0;
         read_addr <= '0;
         kp_valid  <= 1'b0;
         kp_data   <= '0;
         kp_count  <= '0;
         overflow  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_mode   <= mode;
                  kp_count <= '0;
                  overflow <= 1'b0;
                  r_x      <= XW'(1);
                  r_y      <= YW'(1);
                  if (DEGENERATE) begin
                     r_state <= DONE;
                     done    <= 1'b1;
                  end else begin
                     r_state   <= FETCH;
                     busy      <= 1'b1;
                     r_k       <= 4'd0;
                     read_addr <= addrOf(XW'(1), YW'(1), 4'd0);
                  end
               end
            end
            FETCH: begin
               if (r_k == 4'd8) begin
                  r_state   <= WAIT;
                  r_waitCnt <= 4'd0;
               end else begin
                  r_k       <= r_k + 4'd1;
                  read_addr <= addrOf(r_x, r_y, r_k + 4'd1);
               end
            end
            WAIT: begin
               if (r_waitCnt == 4'(READ_LATENCY-1)) r_state <= COMPARE;
               else                                 r_waitCnt <= r_waitCnt + 4'd1;
            end
            COMPARE: begin
               if (w_keypoint) begin
                  if (w_room) begin
                     r_state  <= EMIT;
                     kp_valid <= 1'b1;
                     kp_data  <= {r_y, r_x, w_gtAll};
                  end else begin
                     overflow <= 1'b1;
                  end
               end
            end
            EMIT: begin
               if (kp_ready) begin
                  kp_valid <= 1'b0;
                  kp_count <= kp_count + CW'(1);
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase

         if (w_advance) begin
            r_x <= w_nextX;
            r_y <= w_nextY;
            if (w_scanEnd) begin
               r_state <= DONE;
               busy    <= 1'b0;
               done    <= 1'b1;
            end else begin
               r_state   <= FETCH;
               r_k       <= 4'd0;
               read_addr <= addrOf(w_nextX, w_nextY, 4'd0);
            end
         end
      end
   end

endmodule

// File: tb/tb_dog_extrema_scanner.sv
// Bench for dog_extrema_scanner on an 8x8 octave: directed cases plus random images
// compared against a neighbourhood-scan reference model.
`timescale 1ns/1ps
module tb_dog_extrema_scanner;

   localparam int W    = 8;
   localparam int H    = 8;
   localparam int BD   = 9;
   localparam int L    = 2;
   localparam int TH   = 3;
   localparam int MAXK = 3;
   localparam int AW   = 6;
   localparam int KW   = 7;
   localparam int CW   = 2;

   logic                 clk = 1'b0;
   logic                 rst_in;
   logic                 start;
   logic [1:0]           mode;
   logic [AW-1:0]        read_addr;
   logic signed [BD-1:0] lo_data, mid_data, hi_data;
   logic                 kp_valid;
   logic                 kp_ready;
   logic [KW-1:0]        kp_data;
   logic [CW-1:0]        kp_count;
   logic                 overflow, busy, done;

   logic signed [BD-1:0] loMem  [W*H];
   logic signed [BD-1:0] midMem [W*H];
   logic signed [BD-1:0] hiMem  [W*H];
   logic signed [BD-1:0] loP0, loP1, midP0, midP1, hiP0, hiP1;

   int            total = 0;
   int            bad   = 0;
   logic [KW-1:0] got[$];
   logic [KW-1:0] expKp[$];
   int            busyCycles = 0;
   int            doneCount  = 0;
   int            scanBusy, scanDone, gotBase;

   dog_extrema_scanner #(
      .BIT_DEPTH(BD), .WIDTH(W), .HEIGHT(H), .READ_LATENCY(L),
      .THRESH(TH), .MAX_KEYPOINTS(MAXK)
   ) dut (
      .clk(clk), .rst_in(rst_in), .start(start), .mode(mode),
      .read_addr(read_addr), .lo_data(lo_data), .mid_data(mid_data), .hi_data(hi_data),
      .kp_valid(kp_valid), .kp_ready(kp_ready), .kp_data(kp_data), .kp_count(kp_count),
      .overflow(overflow), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Two-stage BRAM read model: address in one cycle, data two cycles later.
   always @(posedge clk) begin
      loP0 <= loMem[read_addr];   loP1 <= loP0;
      midP0 <= midMem[read_addr]; midP1 <= midP0;
      hiP0 <= hiMem[read_addr];   hiP1 <= hiP0;
   end
   assign lo_data  = loP1;
   assign mid_data = midP1;
   assign hi_data  = hiP1;

   // Monitor on the falling edge, where handshake and status signals are settled.
   always @(negedge clk) begin
      if (kp_valid && kp_ready) got.push_back(kp_data);
      if (busy) busyCycles++;
      if (done) doneCount++;
   end

   function automatic logic [KW-1:0] kpWord(input int x, input int y, input bit isMax);
      return {3'(y), 3'(x), isMax};
   endfunction

   // Reference: every interior pixel checked against its full 3x3x3 neighbourhood.
   function automatic void buildExpected(input logic [1:0] m);
      int c, v, a;
      bit gt, lt;
      expKp.delete();
      for (int y = 1; y < H-1; y++) begin
         for (int x = 1; x < W-1; x++) begin
            c  = int'(midMem[y*W+x]);
            gt = 1'b1;
            lt = 1'b1;
            for (int dy = -1; dy <= 1; dy++) begin
               for (int dx = -1; dx <= 1; dx++) begin
                  for (int z = 0; z < 3; z++) begin
                     if (z == 1 && dy == 0 && dx == 0) continue;
                     v = (z == 0) ? int'(loMem[(y+dy)*W+x+dx]) :
                         (z == 1) ? int'(midMem[(y+dy)*W+x+dx]) : int'(hiMem[(y+dy)*W+x+dx]);
                     if (v >= c) gt = 1'b0;
                     if (v <= c) lt = 1'b0;
                  end
               end
            end
            a = (c < 0) ? -c : c;
            if (((gt && m[0]) || (lt && m[1])) && a >= TH) expKp.push_back(kpWord(x, y, gt));
         end
      end
   endfunction

   task automatic clearMem();
      for (int i = 0; i < W*H; i++) begin
         loMem[i] = '0; midMem[i] = '0; hiMem[i] = '0;
      end
   endtask

   // Start a scan with the given mode and random readiness, then run until done or timeout.
   task automatic runScan(input logic [1:0] m, input int readyPct, output bit timedOut);
      bit finished;
      int bBase, dBase;
      finished = 1'b0;
      bBase    = busyCycles;
      dBase    = doneCount;
      gotBase  = got.size();
      @(posedge clk); #1;
      mode  = m;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      mode  = 2'($urandom);
      for (int n = 0; n < 3000 && !finished; n++) begin
         if (done) finished = 1'b1;
         else begin
            kp_ready = ($urandom_range(99) < readyPct);
            @(posedge clk); #1;
         end
      end
      kp_ready = 1'b0;
      @(negedge clk); #1;
      timedOut = !finished;
      scanBusy = busyCycles - bBase;
      scanDone = doneCount - dBase;
   endtask

   task automatic test_reset();
      rst_in = 1'b1; start = 1'b0; mode = 2'b00; kp_ready = 1'b0;
      clearMem();
      repeat (3) @(posedge clk);
      #1;
      total += 6;
      if (kp_valid !== 1'b0)  begin bad++; $display("[TB] FAIL reset_kp_valid got=%b want=0", kp_valid); end
      if (kp_data !== '0)     begin bad++; $display("[TB] FAIL reset_kp_data got=%h want=0", kp_data); end
      if (kp_count !== '0)    begin bad++; $display("[TB] FAIL reset_kp_count got=%0d want=0", kp_count); end
      if (overflow !== 1'b0)  begin bad++; $display("[TB] FAIL reset_overflow got=%b want=0", overflow); end
      if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy_done got=%b%b want=00", busy, done); end
      if (read_addr !== '0)   begin bad++; $display("[TB] FAIL reset_read_addr got=%0d want=0", read_addr); end
      rst_in = 1'b0;
   endtask

   task automatic test_zero_image();
      bit to;
      clearMem();
      runScan(2'b11, 100, to);
      total += 5;
      if (to)                      begin bad++; $display("[TB] FAIL zero_timeout got=timeout want=done"); end
      if (got.size() != gotBase)   begin bad++; $display("[TB] FAIL zero_kps got=%0d want=0", got.size()-gotBase); end
      if (scanBusy != 432)         begin bad++; $display("[TB] FAIL zero_busy_cycles got=%0d want=432", scanBusy); end
      if (scanDone != 1)           begin bad++; $display("[TB] FAIL zero_done_pulses got=%0d want=1", scanDone); end
      if (kp_count !== 2'd0 || overflow !== 1'b0)
         begin bad++; $display("[TB] FAIL zero_count_ovf got=%0d/%b want=0/0", kp_count, overflow); end
   endtask

   task automatic test_single_max();
      bit to;
      clearMem();
      midMem[4*W+3] = 9'sd20;
      runScan(2'b11, 100, to);
      total += 3;
      if (to || got.size() - gotBase != 1)
         begin bad++; $display("[TB] FAIL single_count got=%0d want=1", got.size()-gotBase); end
      else if (got[gotBase] !== kpWord(3, 4, 1'b1))
         begin bad++; $display("[TB] FAIL single_data got=%h want=%h", got[gotBase], kpWord(3, 4, 1'b1)); end
      if (kp_count !== 2'd1) begin bad++; $display("[TB] FAIL single_kp_count got=%0d want=1", kp_count); end
      if (scanDone != 1)     begin bad++; $display("[TB] FAIL single_done got=%0d want=1", scanDone); end
   endtask

   task automatic test_mode_mask();
      bit to;
      clearMem();
      midMem[4*W+3] = -9'sd20;
      runScan(2'b01, 100, to);
      total++;
      if (to || got.size() != gotBase)
         begin bad++; $display("[TB] FAIL min_masked got=%0d want=0", got.size()-gotBase); end
      runScan(2'b10, 100, to);
      total++;
      if (to || got.size() - gotBase != 1 || got[gotBase] !== kpWord(3, 4, 1'b0))
         begin bad++; $display("[TB] FAIL min_enabled got=%0d kps want=1 (y4 x3 min)", got.size()-gotBase); end
      // Most negative sample must still pass the contrast test.
      midMem[4*W+3] = -9'sd256;
      runScan(2'b10, 100, to);
      total++;
      if (to || got.size() - gotBase != 1 || got[gotBase] !== kpWord(3, 4, 1'b0))
         begin bad++; $display("[TB] FAIL min_most_negative got=%0d kps want=1", got.size()-gotBase); end
      runScan(2'b00, 100, to);
      total++;
      if (to || got.size() != gotBase)
         begin bad++; $display("[TB] FAIL mode_none got=%0d want=0", got.size()-gotBase); end
   endtask

   task automatic test_threshold();
      bit to;
      clearMem();
      midMem[4*W+3] = 9'sd2;
      runScan(2'b11, 100, to);
      total++;
      if (to || got.size() != gotBase)
         begin bad++; $display("[TB] FAIL thresh_below got=%0d want=0", got.size()-gotBase); end
      midMem[4*W+3] = 9'sd3;
      runScan(2'b11, 100, to);
      total++;
      if (to || got.size() - gotBase != 1 || got[gotBase] !== kpWord(3, 4, 1'b1))
         begin bad++; $display("[TB] FAIL thresh_equal got=%0d kps want=1", got.size()-gotBase); end
      midMem[4*W+3] = 9'sd20;
      hiMem[4*W+3]  = 9'sd20;
      runScan(2'b11, 100, to);
      total++;
      if (to || got.size() != gotBase)
         begin bad++; $display("[TB] FAIL tie_rejected got=%0d want=0", got.size()-gotBase); end
   endtask

   task automatic test_backpressure();
      int n;
      logic [KW-1:0] first, second;
      clearMem();
      midMem[2*W+2] = 9'sd30;
      midMem[4*W+5] = 9'sd25;
      first   = kpWord(2, 2, 1'b1);
      second  = kpWord(5, 4, 1'b1);
      gotBase = got.size();
      kp_ready = 1'b0;
      @(posedge clk); #1; mode = 2'b11; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      n = 0;
      while (!kp_valid && n < 2000) begin @(posedge clk); #1; n++; end
      total++;
      if (!kp_valid) begin bad++; $display("[TB] FAIL bp_first_valid got=0 want=1"); end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         total++;
         if (kp_valid !== 1'b1 || kp_data !== first)
            begin bad++; $display("[TB] FAIL bp_hold got=%b/%h want=1/%h", kp_valid, kp_data, first); end
      end
      kp_ready = 1'b1;
      n = 0;
      while (!done && n < 2000) begin @(posedge clk); #1; n++; end
      kp_ready = 1'b0;
      @(negedge clk); #1;
      total += 3;
      if (got.size() - gotBase != 2)
         begin bad++; $display("[TB] FAIL bp_count got=%0d want=2", got.size()-gotBase); end
      else if (got[gotBase] !== first || got[gotBase+1] !== second)
         begin bad++; $display("[TB] FAIL bp_order got=%h,%h want=%h,%h", got[gotBase], got[gotBase+1], first, second); end
      if (kp_count !== 2'd2) begin bad++; $display("[TB] FAIL bp_kp_count got=%0d want=2", kp_count); end
      if (!done && n >= 2000) begin bad++; $display("[TB] FAIL bp_timeout got=timeout want=done"); end
   endtask

   task automatic test_overflow();
      bit to;
      clearMem();
      midMem[1*W+1] = 9'sd10;
      midMem[1*W+4] = 9'sd11;
      midMem[4*W+1] = 9'sd12;
      midMem[4*W+4] = 9'sd13;
      runScan(2'b11, 100, to);
      total += 3;
      if (to || got.size() - gotBase != 3)
         begin bad++; $display("[TB] FAIL ovf_count got=%0d want=3", got.size()-gotBase); end
      else if (got[gotBase+2] !== kpWord(1, 4, 1'b1))
         begin bad++; $display("[TB] FAIL ovf_third got=%h want=%h", got[gotBase+2], kpWord(1, 4, 1'b1)); end
      if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_flag got=%b want=1", overflow); end
      if (kp_count !== 2'd3) begin bad++; $display("[TB] FAIL ovf_kp_count got=%0d want=3", kp_count); end
   endtask

   task automatic test_random();
      bit to;
      int nExp, nEmit;
      logic [1:0] m;
      for (int iter = 0; iter < 8; iter++) begin
         for (int i = 0; i < W*H; i++) begin
            loMem[i]  = 9'(int'($urandom_range(0, 120)) - 60);
            midMem[i] = 9'(int'($urandom_range(0, 120)) - 60);
            hiMem[i]  = 9'(int'($urandom_range(0, 120)) - 60);
         end
         m = (iter < 2) ? 2'b11 : 2'($urandom);
         buildExpected(m);
         nExp  = expKp.size();
         nEmit = (nExp > MAXK) ? MAXK : nExp;
         runScan(m, 60, to);
         total += 3;
         if (to || got.size() - gotBase != nEmit)
            begin bad++; $display("[TB] FAIL rand%0d_count got=%0d want=%0d", iter, got.size()-gotBase, nEmit); end
         else begin
            for (int j = 0; j < nEmit; j++) begin
               total++;
               if (got[gotBase+j] !== expKp[j])
                  begin bad++; $display("[TB] FAIL rand%0d_kp%0d got=%h want=%h", iter, j, got[gotBase+j], expKp[j]); end
            end
         end
         if (kp_count !== CW'(nEmit))
            begin bad++; $display("[TB] FAIL rand%0d_kp_count got=%0d want=%0d", iter, kp_count, nEmit); end
         if (overflow !== (nExp > MAXK))
            begin bad++; $display("[TB] FAIL rand%0d_overflow got=%b want=%b", iter, overflow, nExp > MAXK); end
      end
   endtask

   task automatic test_reset_mid_emit();
      int n;
      bit to;
      clearMem();
      midMem[2*W+2] = 9'sd30;
      midMem[4*W+5] = 9'sd25;
      kp_ready = 1'b0;
      @(posedge clk); #1; mode = 2'b11; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      n = 0;
      while (!kp_valid && n < 2000) begin @(posedge clk); #1; n++; end
      kp_ready = 1'b1;
      @(posedge clk); #1;
      kp_ready = 1'b0;
      n = 0;
      while (!kp_valid && n < 2000) begin @(posedge clk); #1; n++; end
      total += 2;
      if (kp_valid !== 1'b1) begin bad++; $display("[TB] FAIL rst_second_valid got=%b want=1", kp_valid); end
      if (kp_count !== 2'd1) begin bad++; $display("[TB] FAIL rst_pre_count got=%0d want=1", kp_count); end
      #2;
      rst_in = 1'b1;
      #1;
      total += 3;
      if (kp_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_async_valid got=%b want=0", kp_valid); end
      if (busy !== 1'b0)     begin bad++; $display("[TB] FAIL rst_async_busy got=%b want=0", busy); end
      if (kp_count !== 2'd0) begin bad++; $display("[TB] FAIL rst_async_count got=%0d want=0", kp_count); end
      @(posedge clk); #1;
      rst_in = 1'b0;
      clearMem();
      midMem[4*W+3] = 9'sd20;
      runScan(2'b11, 100, to);
      total += 2;
      if (to || got.size() - gotBase != 1 || got[gotBase] !== kpWord(3, 4, 1'b1))
         begin bad++; $display("[TB] FAIL rst_rescan got=%0d kps want=1 (y4 x3 max)", got.size()-gotBase); end
      if (kp_count !== 2'd1) begin bad++; $display("[TB] FAIL rst_rescan_count got=%0d want=1", kp_count); end
   endtask

   initial begin
      test_reset();
      test_zero_image();
      test_single_max();
      test_mode_mask();
      test_threshold();
      test_backpressure();
      test_overflow();
      test_random();
      test_reset_mid_emit();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
